// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter, reads the instruction ROM and holds
// the fetched word in the IF/ID register for decode.
module instr_fetch_unit #(
   parameter int                     PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
   parameter int                     ROM_BYTES = 32
) (
   input  logic                clk,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] PC,
   output logic                en,
   input  logic [31:0]         Instruction_Code,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                id_ready,
   output logic                if_id_valid,
   output logic [31:0]         if_id_instr,
   output logic [PC_WIDTH-1:0] if_id_pc,
   output logic                fault
);

   localparam logic [PC_WIDTH-1:0] ROM_SIZE  = PC_WIDTH'(ROM_BYTES);
   localparam logic [PC_WIDTH-1:0] LAST_WORD = ROM_SIZE - PC_WIDTH'(4);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] pc_seq;
   logic [PC_WIDTH-1:0] target_wrapped;
   logic                misaligned;
   logic                load;

   // Handshake: a word moves to decode on any edge with if_id_valid=1 and
   // id_ready=1; the register reloads when it is empty or being drained, and
   // if_id_instr/if_id_pc stay frozen while valid is held without ready.
   assign pc_seq         = (PC >= LAST_WORD) ? '0 : PC + PC_WIDTH'(4);
   assign target_wrapped = branch_target % ROM_SIZE;
   assign misaligned     = (branch_target[1:0] != 2'b00);
   assign load           = !if_id_valid || id_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= INIT;
         PC          <= RESET_PC;
         en          <= 1'b0;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         if_id_pc    <= '0;
         fault       <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               state <= RUN;
               en    <= 1'b1;
            end
            RUN: begin
               if (branch_taken && misaligned) begin
                  fault       <= 1'b1;
                  if_id_valid <= 1'b0;
                  en          <= 1'b0;
                  state       <= HALT;
               end else if (branch_taken) begin
                  PC          <= target_wrapped;
                  if_id_valid <= 1'b0;
               end else if (load) begin
                  if_id_instr <= Instruction_Code;
                  if_id_pc    <= PC;
                  if_id_valid <= 1'b1;
                  PC          <= pc_seq;
               end
            end
            HALT: begin
               en          <= 1'b0;
               if_id_valid <= 1'b0;
               fault       <= 1'b1;
            end
            default: begin
               state <= INIT;
               en    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run against a behavioural model of the fetch stage.
module tb_instr_fetch_unit;

   localparam int ROM_BYTES = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC;
   logic        en;
   logic [31:0] Instruction_Code;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        id_ready;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        fault;

   int tests_run = 0;
   int fails     = 0;

   logic [7:0]  rom [0:ROM_BYTES-1];
   logic [31:0] exp_q [$];

   // behavioural model of the stage
   logic [31:0] m_pc, m_instr, m_ipc;
   logic        m_valid, m_fault, m_live;

   instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0), .ROM_BYTES(ROM_BYTES)) dut (
      .clk              (clk),
      .reset            (reset),
      .PC               (PC),
      .en               (en),
      .Instruction_Code (Instruction_Code),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .id_ready         (id_ready),
      .if_id_valid      (if_id_valid),
      .if_id_instr      (if_id_instr),
      .if_id_pc         (if_id_pc),
      .fault            (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      int b;
      b = int'(a % ROM_BYTES);
      return {rom[(b + 3) % ROM_BYTES], rom[(b + 2) % ROM_BYTES],
              rom[(b + 1) % ROM_BYTES], rom[b]};
   endfunction

   always_comb Instruction_Code = rom_word(PC);

   // Advance the model by one edge using the inputs currently driven.
   task automatic model_step();
      if (reset) begin
         m_pc = 32'h0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
         m_fault = 1'b0; m_live = 1'b0;
         exp_q.delete();
      end else if (m_fault) begin
         m_valid = 1'b0;
      end else if (!m_live) begin
         m_live = 1'b1;
      end else if (branch_taken) begin
         exp_q.delete();
         m_valid = 1'b0;
         if (branch_target % 4 != 0) m_fault = 1'b1;
         else m_pc = branch_target % ROM_BYTES;
      end else if (!m_valid || id_ready) begin
         if (m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
         m_instr = rom_word(m_pc);
         m_ipc   = m_pc;
         m_valid = 1'b1;
         exp_q.push_back(m_instr);
         m_pc    = (m_pc + 4) % ROM_BYTES;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; id_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
      tick();
      tick();
      tests_run++;
      if (PC !== 32'h0 || en !== 1'b0 || fault !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: PC=%h en=%b fault=%b, expected PC=0 en=0 fault=0", PC, en, fault);
      end
      tests_run++;
      if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc !== 32'h0) begin
         fails++;
         $display("FAIL reset_ifid: valid=%b instr=%h pc=%h, expected all zero", if_id_valid, if_id_instr, if_id_pc);
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp_w [0:1];
      exp_w[0] = 32'h03020100; exp_w[1] = 32'h07060504;
      reset = 1'b0; id_ready = 1'b1;
      tick();
      tests_run++;
      if (en !== 1'b1 || if_id_valid !== 1'b0) begin
         fails++;
         $display("FAIL init_cycle: en=%b valid=%b, expected en=1 valid=0", en, if_id_valid);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (if_id_valid !== 1'b1 || if_id_instr !== exp_w[i] || if_id_pc !== 32'(4 * i)) begin
            fails++;
            $display("FAIL stream_%0d: valid=%b instr=%h pc=%h, expected 1 %h %h",
                     i, if_id_valid, if_id_instr, if_id_pc, exp_w[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_stall();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (if_id_valid !== 1'b1 || if_id_instr !== 32'h07060504 || if_id_pc !== 32'h4 || PC !== 32'h8) begin
            fails++;
            $display("FAIL stall_hold_%0d: valid=%b instr=%h ipc=%h PC=%h, expected 1 07060504 4 8",
                     i, if_id_valid, if_id_instr, if_id_pc, PC);
         end
      end
      id_ready = 1'b1;
      tick();
      tests_run++;
      if (if_id_instr !== 32'h0B0A0908 || if_id_pc !== 32'h8 || PC !== 32'hC) begin
         fails++;
         $display("FAIL stall_resume: instr=%h ipc=%h PC=%h, expected 0B0A0908 8 c", if_id_instr, if_id_pc, PC);
      end
   endtask

   task automatic test_branch();
      id_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h14;
      tick();
      tests_run++;
      if (if_id_valid !== 1'b0 || PC !== 32'h14) begin
         fails++;
         $display("FAIL branch_flush: valid=%b PC=%h, expected 0 14", if_id_valid, PC);
      end
      branch_taken = 1'b0;
      tick();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h14 || if_id_instr !== 32'h17161514) begin
         fails++;
         $display("FAIL branch_fetch: valid=%b ipc=%h instr=%h, expected 1 14 17161514", if_id_valid, if_id_pc, if_id_instr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_ipc [0:2];
      logic [31:0] exp_pc  [0:2];
      exp_ipc[0] = 32'h18; exp_ipc[1] = 32'h1C; exp_ipc[2] = 32'h0;
      exp_pc[0]  = 32'h1C; exp_pc[1]  = 32'h0;  exp_pc[2]  = 32'h4;
      id_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (if_id_pc !== exp_ipc[i] || PC !== exp_pc[i] || if_id_instr !== rom_word(exp_ipc[i])) begin
            fails++;
            $display("FAIL wrap_%0d: ipc=%h PC=%h instr=%h, expected %h %h %h",
                     i, if_id_pc, PC, if_id_instr, exp_ipc[i], exp_pc[i], rom_word(exp_ipc[i]));
         end
      end
      branch_taken = 1'b1; branch_target = 32'h24;
      tick();
      tests_run++;
      if (PC !== 32'h4 || if_id_valid !== 1'b0) begin
         fails++;
         $display("FAIL branch_wrap: PC=%h valid=%b, expected 4 0", PC, if_id_valid);
      end
      branch_taken = 1'b0;
      tick();
      tests_run++;
      if (if_id_pc !== 32'h4 || PC !== 32'h8) begin
         fails++;
         $display("FAIL branch_wrap_fetch: ipc=%h PC=%h, expected 4 8", if_id_pc, PC);
      end
   endtask

   task automatic test_misaligned();
      branch_taken = 1'b1; branch_target = 32'h06;
      tick();
      branch_taken = 1'b0;
      tests_run++;
      if (fault !== 1'b1 || en !== 1'b0 || if_id_valid !== 1'b0 || PC !== 32'h8) begin
         fails++;
         $display("FAIL misaligned: fault=%b en=%b valid=%b PC=%h, expected 1 0 0 8", fault, en, if_id_valid, PC);
      end
      for (int i = 0; i < 10; i++) begin
         id_ready = 1'($urandom_range(0, 1));
         branch_taken = 1'($urandom_range(0, 1));
         branch_target = 32'($urandom_range(0, 15) * 4);
         tick();
         tests_run++;
         if (fault !== 1'b1 || en !== 1'b0 || if_id_valid !== 1'b0 || PC !== 32'h8) begin
            fails++;
            $display("FAIL halt_frozen_%0d: fault=%b en=%b valid=%b PC=%h, expected 1 0 0 8", i, fault, en, if_id_valid, PC);
         end
      end
      branch_taken = 1'b0;
      reset = 1'b1;
      tick();
      tests_run++;
      if (fault !== 1'b0 || en !== 1'b0 || if_id_valid !== 1'b0 || PC !== 32'h0) begin
         fails++;
         $display("FAIL halt_reset: fault=%b en=%b valid=%b PC=%h, expected 0 0 0 0", fault, en, if_id_valid, PC);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b0; id_ready = 1'b1;
      tick();
      tick();
      id_ready = 1'b0;
      tick();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || PC !== 32'h4) begin
         fails++;
         $display("FAIL pre_reset_stall: valid=%b ipc=%h PC=%h, expected 1 0 4", if_id_valid, if_id_pc, PC);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0; id_ready = 1'b1;
      tests_run++;
      if (if_id_valid !== 1'b0 || PC !== 32'h0 || en !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: valid=%b PC=%h en=%b, expected 0 0 0", if_id_valid, PC, en);
      end
      tick();
      tests_run++;
      if (en !== 1'b1 || if_id_valid !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_init: en=%b valid=%b, expected 1 0", en, if_id_valid);
      end
      tick();
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h03020100) begin
         fails++;
         $display("FAIL mid_reset_fetch: valid=%b ipc=%h instr=%h, expected 1 0 03020100", if_id_valid, if_id_pc, if_id_instr);
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         reset         = ($urandom_range(0, 49) == 0);
         id_ready      = ($urandom_range(0, 2) != 0);
         branch_taken  = ($urandom_range(0, 7) == 0);
         branch_target = 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 39) == 0) branch_target = branch_target + 32'($urandom_range(1, 3));
         if (m_fault && $urandom_range(0, 5) == 0) reset = 1'b1;
         if (if_id_valid === 1'b1 && id_ready && !reset) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL sb_unexpected: cycle %0d got %h, expected no word pending", cyc, if_id_instr);
            end else if (if_id_instr !== exp_q[0]) begin
               fails++;
               $display("FAIL sb_word: cycle %0d got %h, expected %h", cyc, if_id_instr, exp_q[0]);
            end
         end
         tick();
         tests_run++;
         if (PC !== m_pc || en !== (m_live && !m_fault) || if_id_valid !== m_valid || fault !== m_fault ||
             if_id_instr !== m_instr || if_id_pc !== m_ipc) begin
            fails++;
            $display("FAIL rand_%0d: PC=%h en=%b v=%b f=%b instr=%h ipc=%h, expected %h %b %b %b %h %h",
                     cyc, PC, en, if_id_valid, fault, if_id_instr, if_id_pc,
                     m_pc, m_live && !m_fault, m_valid, m_fault, m_instr, m_ipc);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'(i);
      m_pc = '0; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_fault = 1'b0; m_live = 1'b0;
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_wrap();
      test_misaligned();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
